// File: rtl/bless_router_pipe.sv
// Bufferless deflection router stage: oldest-first port allocation, single
// ejection, local injection FIFO, registered outputs and a deflection counter.

// Productive-port lookup for one flit: 0=W 1=E 2=S 3=N 4=local.
module bless_route_calc #(
    parameter int COORD_W = 3,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    output logic [2:0]         port
);
    localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);

    // X first, then Y, else the flit has arrived
    always_comb begin
        port = 3'd4;
        if (dst_x > MX)      port = 3'd1;
        else if (dst_x < MX) port = 3'd0;
        else if (dst_y > MY) port = 3'd3;
        else if (dst_y < MY) port = 3'd2;
    end
endmodule

module bless_router_pipe #(
    parameter int PAYLOAD_W = 32,
    parameter int COORD_W   = 3,
    parameter int AGE_W     = 6,
    parameter int MY_X      = 0,
    parameter int MY_Y      = 0,
    parameter int INJ_DEPTH = 4,
    localparam int FW       = AGE_W + 2*COORD_W + PAYLOAD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      in_valid,
    input  logic [4*FW-1:0] in_flit,
    output logic [3:0]      out_valid,
    output logic [4*FW-1:0] out_flit,
    input  logic            inj_valid,
    input  logic [FW-1:0]   inj_flit,
    output logic            inj_ready,
    output logic            ej_valid,
    output logic [FW-1:0]   ej_flit,
    output logic [15:0]     defl_cnt
);
    localparam int AW = $clog2(INJ_DEPTH);
    localparam logic [2:0] P_LOCAL = 3'd4;
    localparam int BODY_W = FW - AGE_W;

    logic [3:0][FW-1:0]    in_f;
    logic [3:0][AGE_W-1:0] in_age;
    logic [3:0][2:0]       prod;
    logic [3:0][1:0]       rank;
    logic [FW-1:0]         head;
    logic [2:0]            head_prod;

    logic [3:0]            out_valid_q, out_valid_d;
    logic [3:0][FW-1:0]    out_flit_q, out_flit_d;
    logic                  ej_valid_q, ej_valid_d;
    logic [FW-1:0]         ej_flit_q, ej_flit_d;
    logic [15:0]           defl_cnt_q, defl_cnt_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  inj_ready_q, inj_ready_d;
    logic [FW-1:0]         mem_q [INJ_DEPTH];

    logic                  push, pop, link_ej;
    logic [3:0]            free;
    logic [2:0]            n_defl;
    logic [1:0]            tgt;
    logic [16:0]           defl_sum;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == '1) ? a : a + AGE_W'(1);
    endfunction

    function automatic logic [1:0] lowest_free(input logic [3:0] f);
        logic [1:0] idx;
        idx = '0;
        for (int k = 3; k >= 0; k--) if (f[k]) idx = 2'(k);
        return idx;
    endfunction

    assign in_f = in_flit;
    assign head = mem_q[rd_ptr_q];

    genvar g;
    for (g = 0; g < 4; g++) begin : g_lane
        assign in_age[g] = in_f[g][FW-1 -: AGE_W];
        bless_route_calc #(.COORD_W(COORD_W), .MY_X(MY_X), .MY_Y(MY_Y)) u_rc (
            .dst_x (in_f[g][PAYLOAD_W+COORD_W +: COORD_W]),
            .dst_y (in_f[g][PAYLOAD_W +: COORD_W]),
            .port  (prod[g])
        );
    end

    bless_route_calc #(.COORD_W(COORD_W), .MY_X(MY_X), .MY_Y(MY_Y)) u_rc_head (
        .dst_x (head[PAYLOAD_W+COORD_W +: COORD_W]),
        .dst_y (head[PAYLOAD_W +: COORD_W]),
        .port  (head_prod)
    );

    // Priority rank per lane: number of lanes that are older, or equally old with lower index
    always_comb begin
        rank = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (j != i && (in_age[j] > in_age[i] || (in_age[j] == in_age[i] && j < i)))
                    rank[i] = rank[i] + 2'd1;
    end

    // Eject, allocate link flits in rank order, then try the FIFO head in leftover ports
    always_comb begin
        free        = 4'hF;
        link_ej     = 1'b0;
        n_defl      = '0;
        tgt         = '0;
        pop         = 1'b0;
        out_valid_d = '0;
        out_flit_d  = '0;
        ej_valid_d  = 1'b0;
        ej_flit_d   = '0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && rank[i] == 2'(r)) begin
                    if (prod[i] == P_LOCAL && !link_ej) begin
                        link_ej    = 1'b1;
                        ej_valid_d = 1'b1;
                        ej_flit_d  = in_f[i];
                    end else begin
                        if (prod[i] != P_LOCAL && free[prod[i][1:0]]) begin
                            tgt = prod[i][1:0];
                        end else begin
                            tgt    = lowest_free(free);
                            n_defl = n_defl + 3'd1;
                        end
                        free[tgt]        = 1'b0;
                        out_valid_d[tgt] = 1'b1;
                        out_flit_d[tgt]  = {age_inc(in_age[i]), in_f[i][BODY_W-1:0]};
                    end
                end
            end
        end
        if (cnt_q != '0 && free != 4'h0) begin
            if (head_prod == P_LOCAL) begin
                if (!link_ej) begin
                    pop        = 1'b1;
                    ej_valid_d = 1'b1;
                    ej_flit_d  = head;
                end
            end else begin
                tgt = free[head_prod[1:0]] ? head_prod[1:0] : lowest_free(free);
                pop              = 1'b1;
                out_valid_d[tgt] = 1'b1;
                out_flit_d[tgt]  = {AGE_W'(1), head[BODY_W-1:0]};
            end
        end
    end

    // Saturating deflection count and FIFO pointer/count bookkeeping
    always_comb begin
        defl_sum   = {1'b0, defl_cnt_q} + 17'(n_defl);
        defl_cnt_d = defl_sum[16] ? 16'hFFFF : defl_sum[15:0];
        push       = inj_valid && inj_ready_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        inj_ready_d = cnt_d < (AW+1)'(INJ_DEPTH);
    end

    // Pipeline registers and FIFO control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_flit_q  <= '0;
            ej_valid_q  <= 1'b0;
            ej_flit_q   <= '0;
            defl_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            inj_ready_q <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            ej_valid_q  <= ej_valid_d;
            ej_flit_q   <= ej_flit_d;
            defl_cnt_q  <= defl_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            inj_ready_q <= inj_ready_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= inj_flit;
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign ej_valid  = ej_valid_q;
    assign ej_flit   = ej_flit_q;
    assign defl_cnt  = defl_cnt_q;
    assign inj_ready = inj_ready_q;
endmodule

// File: tb/tb_bless_router_pipe.sv
// Directed bench for bless_router_pipe at router (1,1), default widths.
module tb_bless_router_pipe;
    localparam int FW = 44;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         in_valid;
    logic [3:0][FW-1:0] tb_in;
    logic [3:0]         out_valid;
    logic [4*FW-1:0]    out_flit;
    logic               inj_valid;
    logic [FW-1:0]      inj_flit;
    logic               inj_ready;
    logic               ej_valid;
    logic [FW-1:0]      ej_flit;
    logic [15:0]        defl_cnt;
    logic [3:0][FW-1:0] exp_o;

    int checks = 0;
    int errors = 0;

    bless_router_pipe #(.MY_X(1), .MY_Y(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(tb_in),
        .out_valid(out_valid), .out_flit(out_flit),
        .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_flit(ej_flit), .defl_cnt(defl_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input int age, input int dx, input int dy, input logic [31:0] pl);
        return {6'(age), 3'(dx), 3'(dy), pl};
    endfunction

    task automatic chk(input string tag, input logic [4*FW-1:0] obs, input logic [4*FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Links carrying one flit to each productive port: no deflections, all ports used
    task automatic links_busy();
        in_valid = 4'b1111;
        tb_in[0] = mk(0, 0, 1, 32'hB0);
        tb_in[1] = mk(0, 2, 1, 32'hB1);
        tb_in[2] = mk(0, 1, 0, 32'hB2);
        tb_in[3] = mk(0, 1, 2, 32'hB3);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; tb_in = '0; inj_valid = 1'b0; inj_flit = '0;
        #12;
        chk("rst_out_valid", out_valid, 4'b0);
        chk("rst_ej_valid", ej_valid, 1'b0);
        chk("rst_inj_ready", inj_ready, 1'b1);
        chk("rst_defl", defl_cnt, 16'd0);
        @(negedge clk); rst_n = 1'b1;

        // single W flit heading east; junk on invalid lanes must be ignored
        in_valid = 4'b0001;
        tb_in[0] = mk(5, 3, 1, 32'hA5A5_0001);
        tb_in[1] = mk(7, 1, 1, 32'hDEAD);
        tb_in[2] = mk(9, 0, 0, 32'hBEEF);
        tb_in[3] = mk(63, 1, 1, 32'hCAFE);
        tick();
        exp_o = '0; exp_o[1] = mk(6, 3, 1, 32'hA5A5_0001);
        chk("single_valid", out_valid, 4'b0010);
        chk("single_flit", out_flit, exp_o);
        chk("single_ej", ej_valid, 1'b0);
        chk("single_defl", defl_cnt, 16'd0);

        // two local flits: older S ejected, E flit deflected to W
        in_valid = 4'b0110;
        tb_in = '0;
        tb_in[1] = mk(2, 1, 1, 32'h11);
        tb_in[2] = mk(7, 1, 1, 32'h22);
        tick();
        exp_o = '0; exp_o[0] = mk(3, 1, 1, 32'h11);
        chk("eject_ej_valid", ej_valid, 1'b1);
        chk("eject_ej_flit", ej_flit, mk(7, 1, 1, 32'h22));
        chk("eject_valid", out_valid, 4'b0001);
        chk("eject_flit", out_flit, exp_o);
        chk("eject_defl", defl_cnt, 16'd1);

        // four flits all heading east, plus a queued west-bound injection
        in_valid = 4'b1111;
        tb_in[0] = mk(9, 2, 1, 32'hC0);
        tb_in[1] = mk(3, 2, 1, 32'hC1);
        tb_in[2] = mk(3, 2, 1, 32'hC2);
        tb_in[3] = mk(1, 2, 1, 32'hC3);
        inj_valid = 1'b1; inj_flit = mk(0, 0, 1, 32'hD0);
        tick();
        inj_valid = 1'b0;
        exp_o[1] = mk(10, 2, 1, 32'hC0);
        exp_o[0] = mk(4, 2, 1, 32'hC1);
        exp_o[2] = mk(4, 2, 1, 32'hC2);
        exp_o[3] = mk(2, 2, 1, 32'hC3);
        chk("contend_flit", out_flit, exp_o);
        chk("contend_defl", defl_cnt, 16'd4);
        tick();
        chk("contend2_flit", out_flit, exp_o);
        chk("contend2_defl", defl_cnt, 16'd7);
        chk("contend2_ej", ej_valid, 1'b0);
        in_valid = 4'b0000;
        tick();
        exp_o = '0; exp_o[0] = mk(1, 0, 1, 32'hD0);
        chk("held_inj_valid", out_valid, 4'b0001);
        chk("held_inj_flit", out_flit, exp_o);
        tick();
        chk("idle_valid", out_valid, 4'b0000);
        chk("idle_flit", out_flit, '0);

        // fill FIFO with all links busy; fifth push refused
        links_busy();
        inj_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inj_flit = mk(0, 2, 1, 32'hF0 + 32'(k));
            tick();
            if (k == 2) chk("fill3_ready", inj_ready, 1'b1);
        end
        chk("full_ready", inj_ready, 1'b0);
        inj_flit = mk(0, 2, 1, 32'hF4);
        tick();
        chk("refused_ready", inj_ready, 1'b0);
        exp_o[0] = mk(1, 0, 1, 32'hB0);
        exp_o[1] = mk(1, 2, 1, 32'hB1);
        exp_o[2] = mk(1, 1, 0, 32'hB2);
        exp_o[3] = mk(1, 1, 2, 32'hB3);
        chk("busy_flit", out_flit, exp_o);
        inj_valid = 1'b0;
        in_valid = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_o[1] = mk(1, 2, 1, 32'hF0 + 32'(k));
            chk($sformatf("drain%0d_valid", k), out_valid, 4'b1111);
            chk($sformatf("drain%0d_flit", k), out_flit, exp_o);
            if (k == 0) chk("drain_ready", inj_ready, 1'b1);
        end
        tick();
        chk("drained_valid", out_valid, 4'b1101);
        chk("drain_defl", defl_cnt, 16'd7);

        // local-destination injection ejects when no link flit ejects
        in_valid = 4'b0000;
        inj_valid = 1'b1; inj_flit = mk(0, 1, 1, 32'hE1);
        tick();
        inj_valid = 1'b0;
        tick();
        chk("inj_ej_valid", ej_valid, 1'b1);
        chk("inj_ej_flit", ej_flit, mk(0, 1, 1, 32'hE1));
        chk("inj_ej_out", out_valid, 4'b0000);

        // asynchronous reset mid-burst with three queued flits
        links_busy();
        inj_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inj_flit = mk(0, 2, 1, 32'h90 + 32'(k));
            tick();
        end
        inj_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 4'b0000);
        chk("arst_flit", out_flit, '0);
        chk("arst_ej", {ej_valid, ej_flit}, '0);
        chk("arst_ready", inj_ready, 1'b1);
        chk("arst_defl", defl_cnt, 16'd0);
        in_valid = 4'b0000;
        @(negedge clk); rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", out_valid, 4'b0000);
        chk("post_rst_ej", ej_valid, 1'b0);

        // drive the counter to saturation: 3 deflections per cycle
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) tb_in[i] = mk(0, 2, 1, 32'(i));
        repeat (21844) tick();
        chk("sat_pre", defl_cnt, 16'hFFFC);
        in_valid = 4'b0111;
        for (int i = 0; i < 3; i++) tb_in[i] = mk(0, 1, 1, 32'(i));
        tick();
        chk("sat_fffe", defl_cnt, 16'hFFFE);
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) tb_in[i] = mk(0, 2, 1, 32'(i));
        tick();
        chk("sat_ffff", defl_cnt, 16'hFFFF);
        tick();
        chk("sat_hold", defl_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
